riscv_mem_arbiter: RTL and testbench
====================================

// Module: riscv_mem_arbiter
// PURPOSE
// Shares one single-port fixed-latency memory between the fetch stage (IF) and the memory stage (DM).
// Fetch stalls and memory-stage stalls come from the gnt/rvalid handshakes below.
// DM normally has priority. A starvation counter guarantees IF progress. IF can be killed on a branch/jump flush.
// One transaction is outstanding at a time.
// PARAMETERS
// ADDR_W      32  address width
// DATA_W      32  data width; BE width is DATA_W/8
// MEM_LAT     2   cycles from the mem_req_o cycle to valid mem_rdata_i; must be >=1
// STARVE_MAX  4   consecutive lost IF arbitrations that force an IF grant
// PORTS
// clk_i        in   1         clock, rising edge
// rst_i        in   1         reset, asynchronous, active-low
// if_req_i     in   1         fetch request; held until if_gnt_o
// if_addr_i    in   ADDR_W    fetch address
// if_kill_i    in   1         flush: block new IF grant, drop in-flight IF response
// if_gnt_o     out  1         one-cycle IF grant pulse
// if_rvalid_o  out  1         one-cycle IF response pulse
// if_rdata_o   out  DATA_W    instruction word, valid with if_rvalid_o
// dm_req_i     in   1         data request; held until dm_gnt_o
// dm_we_i      in   1         1 = store, 0 = load
// dm_be_i      in   DATA_W/8  store byte enables
// dm_addr_i    in   ADDR_W    data address
// dm_wdata_i   in   DATA_W    store data
// dm_gnt_o     out  1         one-cycle DM grant pulse
// dm_rvalid_o  out  1         one-cycle DM response pulse; also fires for stores (ack)
// dm_rdata_o   out  DATA_W    load data; 0 for stores
// mem_req_o    out  1         one-cycle memory strobe
// mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  memory command, held until the next issue
// mem_rdata_i  in   DATA_W    memory read data
// busy_o       out  1         1 when state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0, starve=0, drop=0. Every output is 0.
// - Reset mid-transaction: the transaction is abandoned, no rvalid is issued, and the block returns to IDLE.
// - States IDLE, BUSY. All outputs are registered.
// - IDLE, arbitration on each cycle. Eligible IF = if_req_i & ~if_kill_i.
//   - Winner is IF if starve>=STARVE_MAX and IF is eligible.
//   - Otherwise winner is DM if dm_req_i.
//   - Otherwise winner is IF if eligible.
//   - On a winner at edge N: latch owner and command into the mem_* regs (IF: we=0, be=all-ones, wdata=0).
//     In cycle N+1: pulse the owner's gnt_o and mem_req_o, cnt=MEM_LAT, state=BUSY.
// - BUSY: cnt decrements each cycle. When cnt==0:
//   - sample mem_rdata_i into the owner's rdata reg;
//   - next cycle pulse the owner's rvalid_o, unless owner=IF and drop=1;
//   - state goes to IDLE.
//   Requests are ignored in BUSY.
// - Latency: request at cycle 0 gives gnt/mem_req at 1, sampling at 1+MEM_LAT, rvalid at 2+MEM_LAT.
//   The next grant is issued no earlier than 3+MEM_LAT.
// - Starvation counter:
//   - increments, saturating at STARVE_MAX, when IF is eligible in IDLE and DM wins;
//   - clears when IF is granted or if_req_i=0.
// - Kill:
//   - In IDLE, kill blocks an IF grant that cycle.
//   - In BUSY with owner=IF, kill sets drop. The memory read still completes (memory cannot be cancelled), but if_rvalid_o is suppressed.
//   - drop clears on return to IDLE. Kill has no effect on a DM transaction.
// - Simultaneous IF/DM requests with starve<STARVE_MAX: DM wins; IF keeps its request asserted.
// - rdata regs hold their value between responses. mem_* command regs hold after the issue cycle; only mem_req_o pulses.
// - Address is passed through unmodified. Alignment is the requester's responsibility.
// STRUCTURE
// - Shared package riscv_mem_pkg: state enum {IDLE,BUSY}, owner enum {OWN_IF,OWN_DM}, default MEM_LAT, BE_ALL constant.
// - cnt width is $clog2(MEM_LAT+1). The starve width is $clog2(STARVE_MAX+1).
// - One sub-module is natural: riscv_mem_arb_prio, holding the starvation counter plus the winner-select logic.
//   The FSM and datapath regs stay in this module.
// TESTING (MEM_LAT=2, STARVE_MAX=4)
// 1. IF read: if_req=1, addr=0x100 at cycle 0; mem_rdata=0x00500093 at cycle 3
//    -> if_gnt=1 and mem_req=1 at cycle 1, if_rvalid=1 with if_rdata=0x00500093 at cycle 4, busy low at cycle 4.
// 2. DM store: we=1, be=4'b0011, addr=0x2000, wdata=0xDEADBEEF
//    -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF at the issue cycle; dm_rvalid=1 with dm_rdata=0 at issue+3.
// 3. Contention: IF and DM held high continuously
//    -> grants DM,DM,DM,DM then IF on the 5th; starve returns to 0 afterwards.
// 4. Kill: IF granted at cycle 1, if_kill=1 at cycle 2 -> no if_rvalid at cycle 4; next grant possible at cycle 5.
//    Kill concurrent with if_req in IDLE and no DM request -> no grant.
// 5. Reset: drop rst_i at BUSY cnt=1 -> all outputs 0 immediately, state IDLE.
//    After release, a fresh IF request completes normally.
// 6. Back-to-back DM loads 0x10, 0x14 -> second gnt exactly 1 cycle after the first dm_rvalid; no lost or duplicated rvalid.

Source files
------------

// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory arbiter.
package riscv_mem_pkg;

   typedef enum logic {IDLE, BUSY} state_e;
   typedef enum logic {OWN_IF, OWN_DM} owner_e;

   localparam int unsigned MEM_LAT_DEF = 2;

   // Wide enough for any practical data width; users slice the low DATA_W/8 bits.
   localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the fetch/memory stages, the arbiter and the shared memory.
interface riscv_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned BE_W = DATA_W / 8;

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_kill_i;
   logic              if_gnt_o;
   logic              if_rvalid_o;
   logic [DATA_W-1:0] if_rdata_o;

   logic              dm_req_i;
   logic              dm_we_i;
   logic [BE_W-1:0]   dm_be_i;
   logic [ADDR_W-1:0] dm_addr_i;
   logic [DATA_W-1:0] dm_wdata_i;
   logic              dm_gnt_o;
   logic              dm_rvalid_o;
   logic [DATA_W-1:0] dm_rdata_o;

   logic              mem_req_o;
   logic              mem_we_o;
   logic [BE_W-1:0]   mem_be_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i, if_kill_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output if_req_i, if_addr_i, if_kill_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
      input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );

endinterface

// File: rtl/riscv_mem_arbiter_prio.sv
// Winner selection between IF and DM with a saturating IF starvation counter.
module riscv_mem_arb_prio
   import riscv_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   idle_i,
   input  logic   if_req_i,
   input  logic   if_kill_i,
   input  logic   dm_req_i,
   output logic   win_valid_o,
   output owner_e win_owner_o
);
   localparam int unsigned ST_W = $clog2(STARVE_MAX + 1);

   logic [ST_W-1:0] starve_q, starve_d;
   logic            if_elig;
   logic            force_if;

   assign if_elig  = if_req_i & ~if_kill_i;
   assign force_if = if_elig & (starve_q >= ST_W'(STARVE_MAX));

   always_comb begin
      win_valid_o = idle_i & (if_elig | dm_req_i);
      win_owner_o = (force_if | ~dm_req_i) ? OWN_IF : OWN_DM;
   end

   always_comb begin
      starve_d = starve_q;
      if (!if_req_i || (win_valid_o && win_owner_o == OWN_IF)) begin
         starve_d = '0;
      end else if (win_valid_o && win_owner_o == OWN_DM && if_elig &&
                   starve_q < ST_W'(STARVE_MAX)) begin
         starve_d = starve_q + ST_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) starve_q <= '0;
      else         starve_q <= starve_d;
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port fixed-latency memory shared by fetch (IF) and memory stage (DM).
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   riscv_mem_arbiter_if.slave bus,
   output logic               busy_o
);
   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              drop_q, drop_d;

   logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
   logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

   logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              win_valid;
   owner_e            win_owner;

   riscv_mem_arb_prio #(
      .STARVE_MAX(STARVE_MAX)
   ) u_prio (
      .clk_i      (clk_i),
      .rst_ni     (rst_i),
      .idle_i     (state_q == IDLE),
      .if_req_i   (bus.if_req_i),
      .if_kill_i  (bus.if_kill_i),
      .dm_req_i   (bus.dm_req_i),
      .win_valid_o(win_valid),
      .win_owner_o(win_owner)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      drop_d      = drop_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      mem_req_d   = 1'b0;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (win_valid) begin
               state_d   = BUSY;
               owner_d   = win_owner;
               cnt_d     = CNT_W'(MEM_LAT);
               mem_req_d = 1'b1;
               if (win_owner == OWN_IF) begin
                  if_gnt_d    = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_be_d    = BE_ALL[BE_W-1:0];
                  mem_addr_d  = bus.if_addr_i;
                  mem_wdata_d = '0;
               end else begin
                  dm_gnt_d    = 1'b1;
                  mem_we_d    = bus.dm_we_i;
                  mem_be_d    = bus.dm_be_i;
                  mem_addr_d  = bus.dm_addr_i;
                  mem_wdata_d = bus.dm_wdata_i;
               end
            end
         end
         BUSY: begin
            if (owner_q == OWN_IF && bus.if_kill_i) drop_d = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = IDLE;
               drop_d  = 1'b0;
               // A kill arriving in the sampling cycle itself also suppresses the response.
               if (owner_q == OWN_IF) begin
                  if_rdata_d  = bus.mem_rdata_i;
                  if_rvalid_d = ~(drop_q | bus.if_kill_i);
               end else begin
                  dm_rdata_d  = mem_we_q ? '0 : bus.mem_rdata_i;
                  dm_rvalid_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= '0;
         drop_q      <= 1'b0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         drop_q      <= drop_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.if_gnt_o    = if_gnt_q;
   assign bus.if_rvalid_o = if_rvalid_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.dm_gnt_o    = dm_gnt_q;
   assign bus.dm_rvalid_o = dm_rvalid_q;
   assign bus.dm_rdata_o  = dm_rdata_q;
   assign bus.mem_req_o   = mem_req_q;
   assign bus.mem_we_o    = mem_we_q;
   assign bus.mem_be_o    = mem_be_q;
   assign bus.mem_addr_o  = mem_addr_q;
   assign bus.mem_wdata_o = mem_wdata_q;
   assign busy_o          = (state_q == BUSY);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with MEM_LAT=2, STARVE_MAX=4.
module tb_riscv_mem_arbiter;

   logic clk_i;
   logic rst_i;
   logic busy_o;

   int unsigned n_pass;
   int unsigned n_total;

   riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   riscv_mem_arbiter #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MEM_LAT   (2),
      .STARVE_MAX(4)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus),
      .busy_o(busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   logic [7:0]  gk [6];
   int unsigned gc [6];
   int unsigned ng;
   logic [7:0]  exp_k [6];
   int unsigned exp_c [6];

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst_i   = 1'b0;
      bus.if_req_i    = 1'b0;
      bus.if_addr_i   = '0;
      bus.if_kill_i   = 1'b0;
      bus.dm_req_i    = 1'b0;
      bus.dm_we_i     = 1'b0;
      bus.dm_be_i     = '0;
      bus.dm_addr_i   = '0;
      bus.dm_wdata_i  = '0;
      bus.mem_rdata_i = '0;

      // Reset state
      tick(); tick();
      chk("rst_busy",      busy_o,          0);
      chk("rst_if_gnt",    bus.if_gnt_o,    0);
      chk("rst_dm_gnt",    bus.dm_gnt_o,    0);
      chk("rst_if_rvalid", bus.if_rvalid_o, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid_o, 0);
      chk("rst_mem_req",   bus.mem_req_o,   0);
      chk("rst_mem_be",    bus.mem_be_o,    0);
      chk("rst_mem_addr",  bus.mem_addr_o,  0);
      rst_i = 1'b1;
      tick();

      // 1. IF read
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h100;
      tick();
      chk("t1_if_gnt",   bus.if_gnt_o,   1);
      chk("t1_mem_req",  bus.mem_req_o,  1);
      chk("t1_mem_addr", bus.mem_addr_o, 32'h100);
      chk("t1_mem_we",   bus.mem_we_o,   0);
      chk("t1_mem_be",   bus.mem_be_o,   4'hF);
      chk("t1_busy",     busy_o,         1);
      bus.if_req_i    = 1'b0;
      bus.mem_rdata_i = 32'hDEAD0000;
      tick();
      chk("t1_gnt_pulse", bus.if_gnt_o,   0);
      chk("t1_req_pulse", bus.mem_req_o,  0);
      chk("t1_addr_hold", bus.mem_addr_o, 32'h100);
      tick();
      bus.mem_rdata_i = 32'h00500093;
      tick();
      chk("t1_if_rvalid", bus.if_rvalid_o, 1);
      chk("t1_if_rdata",  bus.if_rdata_o,  32'h00500093);
      chk("t1_busy_low",  busy_o,          0);
      chk("t1_dm_rvalid", bus.dm_rvalid_o, 0);
      tick();
      chk("t1_rvalid_pulse", bus.if_rvalid_o, 0);
      chk("t1_rdata_hold",   bus.if_rdata_o,  32'h00500093);

      // 2. DM store
      bus.dm_req_i   = 1'b1;
      bus.dm_we_i    = 1'b1;
      bus.dm_be_i    = 4'b0011;
      bus.dm_addr_i  = 32'h2000;
      bus.dm_wdata_i = 32'hDEADBEEF;
      tick();
      chk("t2_dm_gnt",    bus.dm_gnt_o,    1);
      chk("t2_mem_we",    bus.mem_we_o,    1);
      chk("t2_mem_be",    bus.mem_be_o,    4'b0011);
      chk("t2_mem_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
      chk("t2_mem_addr",  bus.mem_addr_o,  32'h2000);
      bus.dm_req_i    = 1'b0;
      bus.dm_we_i     = 1'b0;
      bus.mem_rdata_i = 32'h12345678;
      tick(); tick(); tick();
      chk("t2_dm_rvalid", bus.dm_rvalid_o, 1);
      chk("t2_dm_rdata",  bus.dm_rdata_o,  0);
      chk("t2_if_rvalid", bus.if_rvalid_o, 0);
      tick();

      // 3. Contention: both requests held, grants every 4 cycles
      exp_k = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};
      exp_c = '{1, 5, 9, 13, 17, 21};
      for (int i = 0; i < 6; i++) begin
         gk[i] = 8'h58;
         gc[i] = 0;
      end
      ng = 0;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h500;
      bus.dm_req_i  = 1'b1;
      bus.dm_addr_i = 32'h600;
      for (int c = 1; c <= 40 && ng < 6; c++) begin
         tick();
         if (bus.if_gnt_o && bus.dm_gnt_o)
            chk("t3_gnt_excl", {bus.if_gnt_o, bus.dm_gnt_o}, 2'b01);
         if (bus.if_gnt_o || bus.dm_gnt_o) begin
            gk[ng] = bus.if_gnt_o ? 8'h49 : 8'h44;
            gc[ng] = c;
            ng++;
         end
      end
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t3_gnt%0d_who", i), gk[i], exp_k[i]);
         chk($sformatf("t3_gnt%0d_cyc", i), gc[i], exp_c[i]);
      end
      bus.if_req_i = 1'b0;
      bus.dm_req_i = 1'b0;
      for (int c = 0; c < 10 && busy_o; c++) tick();
      chk("t3_idle", busy_o, 0);
      tick();

      // 4. Kill of an in-flight IF read
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h200;
      tick();
      chk("t4_if_gnt", bus.if_gnt_o, 1);
      bus.if_req_i  = 1'b0;
      tick();
      bus.if_kill_i = 1'b1;
      tick();
      bus.if_kill_i   = 1'b0;
      bus.mem_rdata_i = 32'h0000CAFE;
      tick();
      chk("t4_no_rvalid", bus.if_rvalid_o, 0);
      chk("t4_busy_low",  busy_o,          0);
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h204;
      tick();
      chk("t4_regnt",     bus.if_gnt_o,   1);
      chk("t4_regnt_adr", bus.mem_addr_o, 32'h204);
      bus.if_req_i = 1'b0;
      tick(); tick();
      bus.mem_rdata_i = 32'h00001111;
      tick();
      chk("t4_rvalid_after", bus.if_rvalid_o, 1);
      chk("t4_rdata_after",  bus.if_rdata_o,  32'h00001111);
      bus.if_req_i  = 1'b1;
      bus.if_kill_i = 1'b1;
      tick();
      chk("t4_kill_idle_gnt",  bus.if_gnt_o, 0);
      chk("t4_kill_idle_busy", busy_o,       0);
      tick();
      chk("t4_kill_idle_gnt2", bus.if_gnt_o, 0);
      bus.if_req_i  = 1'b0;
      bus.if_kill_i = 1'b0;
      tick();

      // 5. Reset in the middle of a transaction (cnt=1)
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h300;
      tick();
      chk("t5_if_gnt", bus.if_gnt_o, 1);
      bus.if_req_i = 1'b0;
      tick();
      rst_i = 1'b0;
      #1;
      chk("t5_rst_busy",     busy_o,         0);
      chk("t5_rst_mem_addr", bus.mem_addr_o, 0);
      chk("t5_rst_mem_be",   bus.mem_be_o,   0);
      chk("t5_rst_if_rdata", bus.if_rdata_o, 0);
      bus.mem_rdata_i = 32'h77777777;
      tick();
      tick();
      chk("t5_no_rvalid", bus.if_rvalid_o, 0);
      rst_i = 1'b1;
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 32'h400;
      tick();
      chk("t5_fresh_gnt",  bus.if_gnt_o,   1);
      chk("t5_fresh_addr", bus.mem_addr_o, 32'h400);
      bus.if_req_i = 1'b0;
      tick(); tick();
      bus.mem_rdata_i = 32'h0BADCAFE;
      tick();
      chk("t5_fresh_rvalid", bus.if_rvalid_o, 1);
      chk("t5_fresh_rdata",  bus.if_rdata_o,  32'h0BADCAFE);
      tick();

      // 6. Back-to-back DM loads
      bus.dm_req_i  = 1'b1;
      bus.dm_we_i   = 1'b0;
      bus.dm_addr_i = 32'h10;
      tick();
      chk("t6_gnt1",  bus.dm_gnt_o,   1);
      chk("t6_addr1", bus.mem_addr_o, 32'h10);
      bus.dm_addr_i = 32'h14;
      tick(); tick();
      bus.mem_rdata_i = 32'hAAAA0010;
      tick();
      chk("t6_rvalid1", bus.dm_rvalid_o, 1);
      chk("t6_rdata1",  bus.dm_rdata_o,  32'hAAAA0010);
      chk("t6_nognt",   bus.dm_gnt_o,    0);
      tick();
      chk("t6_gnt2",        bus.dm_gnt_o,    1);
      chk("t6_addr2",       bus.mem_addr_o,  32'h14);
      chk("t6_rvalid1_end", bus.dm_rvalid_o, 0);
      bus.dm_req_i = 1'b0;
      tick(); tick();
      bus.mem_rdata_i = 32'hBBBB0014;
      tick();
      chk("t6_rvalid2", bus.dm_rvalid_o, 1);
      chk("t6_rdata2",  bus.dm_rdata_o,  32'hBBBB0014);
      tick();
      chk("t6_no_dup",  bus.dm_rvalid_o, 0);
      chk("t6_no_gnt3", bus.dm_gnt_o,    0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
